// File: rtl/stream_pkg.sv
// Shared types for the packed-beat stream path: default geometry, beat/item types, FSM states.
package stream_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LANES_DEF  = 3;
  localparam int unsigned CNT_W_LANE = $clog2(LANES_DEF + 1);

  typedef struct packed {
    logic [LANES_DEF-1:0][DATA_W_DEF-1:0] data;
    logic [CNT_W_LANE-1:0]                cnt;
  } packed_beat_t;

  typedef logic [DATA_W_DEF-1:0] item_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/stream_unpacker.sv
// Re-serialises packed multi-lane beats into one item per cycle over a valid/ready stream.
// Holds one beat; the last-lane fire can accept the next beat in the same cycle (no bubble).
module stream_unpacker
  import stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_bits_data,
  input  logic [$clog2(LANES+1)-1:0] in_bits_cnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_bits,
  output logic                       out_last,
  output logic                       err_cnt,
  output logic [CNT_W-1:0]           in_beats,
  output logic [CNT_W-1:0]           out_items
);

  localparam int unsigned CW    = $clog2(LANES + 1);
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                       r_state, w_state_nxt;
  logic [LANES-1:0][DATA_W-1:0] r_data, w_data_nxt;
  logic [CW-1:0]                r_cnt, w_cnt_nxt, w_cnt_clamp;
  logic [IDX_W-1:0]             r_idx, w_idx_nxt;
  logic                         r_live;
  logic                         r_err, w_err_nxt;
  logic [CNT_W-1:0]             r_in_beats, r_out_items;

  logic w_busy, w_last, w_fire, w_acc, w_cnt_zero, w_cnt_over;

  assign w_busy     = (r_state == DRAIN);
  assign w_last     = w_busy && ((CW'(r_idx) + CW'(1)) == r_cnt);
  assign w_fire     = w_busy && out_ready;
  // r_live keeps in_ready low while reset is held and releases it one edge later
  assign in_ready   = r_live && (!w_busy || (w_fire && w_last));
  assign w_acc      = in_valid && in_ready;

  assign w_cnt_zero  = (in_bits_cnt == '0);
  assign w_cnt_over  = (int'(in_bits_cnt) > int'(LANES));
  assign w_cnt_clamp = w_cnt_over ? CW'(LANES) : in_bits_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;

    if (w_fire && !w_last) begin
      w_idx_nxt = r_idx + IDX_W'(1);
    end

    if (w_acc) begin
      if (w_cnt_zero || w_cnt_over) begin
        w_err_nxt = 1'b1;
      end
      if (w_cnt_zero) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = DRAIN;
        w_data_nxt  = in_bits_data;
        w_cnt_nxt   = w_cnt_clamp;
        w_idx_nxt   = '0;
      end
    end else if (w_fire && w_last) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_live      <= 1'b0;
      r_err       <= 1'b0;
      r_in_beats  <= '0;
      r_out_items <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_live  <= 1'b1;
      r_err   <= w_err_nxt;
      if (w_acc) begin
        r_in_beats <= r_in_beats + CNT_W'(1);
      end
      if (w_fire) begin
        r_out_items <= r_out_items + CNT_W'(1);
      end
    end
  end

  assign out_valid = w_busy;
  assign out_bits  = w_busy ? r_data[r_idx] : '0;
  assign out_last  = w_last;
  assign err_cnt   = r_err;
  assign in_beats  = r_in_beats;
  assign out_items = r_out_items;

endmodule

// File: tb/tb_stream_unpacker.sv
// Self-checking bench for stream_unpacker: directed table, corner sequences, random vs queue model.
module tb_stream_unpacker;

  localparam int DW = 8;
  localparam int LN = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [23:0]   in_bits_data = '0;
  logic [1:0]    in_bits_cnt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_bits;
  logic          out_last;
  logic          err_cnt;
  logic [15:0]   in_beats;
  logic [15:0]   out_items;

  always #5 clock = ~clock;

  stream_unpacker #(.DATA_W(DW), .LANES(LN), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits_data(in_bits_data), .in_bits_cnt(in_bits_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_last(out_last),
    .err_cnt(err_cnt), .in_beats(in_beats), .out_items(out_items)
  );

  // Reference model: queue of items still owed from the beat currently held.
  typedef struct { logic [7:0] d; logic last; } item_s;
  item_s       q[$];
  logic [7:0]  obs[$];
  int unsigned m_beats, m_items, steps;
  logic        m_err;
  bit          m_acc;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [23:0] d;
    logic [1:0]  c;
    int          n;
    logic [7:0]  e0, e1, e2;
    logic        err;
  } vec_s;
  vec_s tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [23:0] d, input logic [1:0] c, input logic ordy);
    logic exp_rdy;
    int   n;
    @(negedge clock);
    in_valid = iv; in_bits_data = d; in_bits_cnt = c; out_ready = ordy;
    #3;
    exp_rdy = (q.size() == 0) || (ordy && q.size() == 1);
    check("in_ready",  32'(in_ready),  32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("out_bits",  32'(out_bits),  (q.size() > 0) ? 32'(q[0].d) : 32'h0);
    check("out_last",  32'(out_last),  (q.size() > 0) ? 32'(q[0].last) : 32'h0);
    check("err_cnt",   32'(err_cnt),   32'(m_err));
    check("in_beats",  32'(in_beats),  32'(m_beats[15:0]));
    check("out_items", 32'(out_items), 32'(m_items[15:0]));
    if (q.size() > 0 && ordy) begin
      obs.push_back(q[0].d);
      void'(q.pop_front());
      m_items++;
    end
    m_acc = iv && exp_rdy;
    if (m_acc) begin
      m_beats++;
      n = (c == 0) ? 0 : ((int'(c) > LN) ? LN : int'(c));
      if (c == 0 || int'(c) > LN) m_err = 1'b1;
      for (int k = 0; k < n; k++) q.push_back('{d: d[k*8 +: 8], last: (k == n-1)});
    end
    steps++;
    @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_ctl",  32'({in_ready, out_valid, out_last, err_cnt}), 32'h0);
    check("rst_bits", 32'(out_bits), 32'h0);
    check("rst_cnts", {in_beats, out_items}, 32'h0);
    q.delete();
    m_beats = 0; m_items = 0; m_err = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
  endtask

  task automatic send(input logic [23:0] d, input logic [1:0] c, input int unsigned rdy_pct);
    int guard = 0;
    do begin
      step(1'b1, d, c, ($urandom_range(0, 99) < rdy_pct));
      guard++;
    end while (!m_acc && guard < 60);
    if (!m_acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %h not accepted within %0d cycles", d, guard);
    end
  endtask

  task automatic drain(input int n, input int unsigned rdy_pct);
    for (int i = 0; i < n; i++)
      step(1'b0, 24'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < rdy_pct));
  endtask

  initial begin
    tbl[0] = '{d: 24'h030201, c: 2'd3, n: 3, e0: 8'h01, e1: 8'h02, e2: 8'h03, err: 1'b0};
    tbl[1] = '{d: 24'h5566AA, c: 2'd1, n: 1, e0: 8'hAA, e1: 8'h00, e2: 8'h00, err: 1'b0};
    tbl[2] = '{d: 24'hC0B0A0, c: 2'd2, n: 2, e0: 8'hA0, e1: 8'hB0, e2: 8'h00, err: 1'b0};
    tbl[3] = '{d: 24'h123456, c: 2'd0, n: 0, e0: 8'h00, e1: 8'h00, e2: 8'h00, err: 1'b1};
    tbl[4] = '{d: 24'hFF0011, c: 2'd3, n: 3, e0: 8'h11, e1: 8'h00, e2: 8'hFF, err: 1'b1};

    do_reset();

    // Directed table: full, partial and cnt==0 beats with free-running sink
    for (int i = 0; i < 5; i++) begin
      obs.delete();
      send(tbl[i].d, tbl[i].c, 100);
      drain(4, 100);
      #1;
      check($sformatf("tbl%0d_n", i), 32'(obs.size()), 32'(tbl[i].n));
      if (tbl[i].n > 0) check($sformatf("tbl%0d_i0", i), 32'(obs[0]), 32'(tbl[i].e0));
      if (tbl[i].n > 1) check($sformatf("tbl%0d_i1", i), 32'(obs[1]), 32'(tbl[i].e1));
      if (tbl[i].n > 2) check($sformatf("tbl%0d_i2", i), 32'(obs[2]), 32'(tbl[i].e2));
      check($sformatf("tbl%0d_err", i), 32'(err_cnt), 32'(tbl[i].err));
      if (i == 0) begin
        check("tbl0_in_beats", 32'(in_beats), 32'd1);
        check("tbl0_out_items", 32'(out_items), 32'd3);
      end
    end

    // Back-to-back full beats: beat k accepted on step 1+3k, no bubble between beats
    do_reset();
    obs.delete();
    steps = 0;
    for (int b = 0; b < 10; b++) send({8'(b*16+2), 8'(b*16+1), 8'(b*16)}, 2'd3, 100);
    check("b2b_accept_steps", 32'(steps), 32'd28);
    drain(3, 100);
    check("b2b_items", 32'(obs.size()), 32'd30);
    for (int j = 0; j < 30 && j < obs.size(); j++)
      check($sformatf("b2b_item%0d", j), 32'(obs[j]), 32'((j/3)*16 + (j%3)));

    // Backpressure 1,0,0,1,1 with the next beat offered throughout
    obs.delete();
    send(24'h332211, 2'd3, 100);
    step(1'b1, 24'h665544, 2'd3, 1'b1);
    step(1'b1, 24'h665544, 2'd3, 1'b0);
    step(1'b1, 24'h665544, 2'd3, 1'b0);
    step(1'b1, 24'h665544, 2'd3, 1'b1);
    check("bp_not_early", 32'(m_beats), 32'd11);
    step(1'b1, 24'h665544, 2'd3, 1'b1);
    drain(4, 100);
    check("bp_items", 32'(obs.size()), 32'd6);
    for (int j = 0; j < 6 && j < obs.size(); j++)
      check($sformatf("bp_item%0d", j), 32'(obs[j]), 32'(8'h11 * (j + 1)));

    // Last-lane fire coinciding with accept of a cnt==0 beat
    do_reset();
    send(24'h0C0B0A, 2'd3, 100);
    for (int i = 0; i < 3; i++) step(1'b1, 24'hDEADBE, 2'd0, 1'b1);
    step(1'b0, 24'h0, 2'd0, 1'b1);
    #1;
    check("drop_err", 32'(err_cnt), 32'd1);
    check("drop_idle", 32'(out_valid), 32'd0);
    check("drop_beats", 32'(in_beats), 32'd2);
    check("drop_items", 32'(out_items), 32'd3);

    // Random traffic against the queue model, with a reset in the middle of a drain
    do_reset();
    for (int b = 0; b < 80; b++) begin
      int unsigned pct = $urandom_range(30, 100);
      drain($urandom_range(0, 10), pct);
      send(24'($urandom), (b == 40) ? 2'd3 : 2'($urandom_range(1, 3)), pct);
      if (b == 40) begin
        do_reset();
        drain(3, 100);
        #1;
        check("rst_no_stale", 32'(out_items), 32'd0);
      end
    end
    drain(20, 100);
    #1;
    check("rand_final_items", 32'(out_items), 32'(m_items[15:0]));
    check("rand_final_idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
